// File: rtl/jtdd_timing_pkg.sv
// jtdd_timing_pkg: default raster timing for the Double Dragon video chain.
// Shared by the timing generator, the main CPU glue and the video blocks.
package jtdd_timing_pkg;

    localparam int HTOTAL_DEF   = 384;
    localparam int VTOTAL_DEF   = 272;
    localparam int HB_START_DEF = 256;
    localparam int HS_START_DEF = 288;
    localparam int HS_END_DEF   = 319;
    localparam int VB_START_DEF = 248;
    localparam int VB_END_DEF   = 8;
    localparam int VS_START_DEF = 252;
    localparam int VS_END_DEF   = 255;

    localparam int CW = 9;

    typedef logic [CW-1:0] cnt_t;

    function automatic logic in_win(
        cnt_t x,
        cnt_t lo,
        cnt_t hi
    );
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/jtdd_timing_if.sv
// jtdd_timing_if: pixel enable and flip request in, raster
// counters, blanking and sync out.
interface jtdd_timing_if;
    import jtdd_timing_pkg::*;

    logic       cen6;
    logic       flip;
    cnt_t       H;
    cnt_t       V;
    logic [7:0] HF;
    logic [7:0] VF;
    logic       Hinit;
    logic       LHBL;
    logic       LVBL;
    logic       VBL;
    logic       IMS;
    logic       HS;
    logic       VS;

    modport master (
        input  cen6, flip,
        output H, V, HF, VF, Hinit,
        output LHBL, LVBL, VBL, IMS,
        output HS, VS
    );

    modport slave (
        output cen6, flip,
        input  H, V, HF, VF, Hinit,
        input  LHBL, LVBL, VBL, IMS,
        input  HS, VS
    );

endinterface

// File: rtl/jtdd_tcnt.sv
// jtdd_tcnt: modulo-MAX counter with carry out on the terminal count.
// nxt exposes the next value so callers can register decodes with no lag.
module jtdd_tcnt #(
    parameter int W   = 9,
    parameter int MAX = 384
)(
    input  logic         clk,
    input  logic         nRESET,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W-1:0] nxt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign wrap = en && (cnt == LAST);

    always_comb begin
        nxt = cnt;
        if (wrap)
            nxt = '0;
        else if (en)
            nxt = cnt + W'(1);
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET)
            cnt <= '0;
        else
            cnt <= nxt;
    end

endmodule

// File: rtl/jtdd_timing.sv
// jtdd_timing: H/V raster counters with registered blanking, sync,
// IMS interrupt source and frame-latched screen flip.
module jtdd_timing
    import jtdd_timing_pkg::*;
#(
    parameter int HTOTAL   = HTOTAL_DEF,
    parameter int VTOTAL   = VTOTAL_DEF,
    parameter int HB_START = HB_START_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_END   = HS_END_DEF,
    parameter int VB_START = VB_START_DEF,
    parameter int VB_END   = VB_END_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_END   = VS_END_DEF
)(
    input  logic          clk,
    input  logic          nRESET,
    jtdd_timing_if.master vid
);

    localparam cnt_t HB  = cnt_t'(HB_START);
    localparam cnt_t HSS = cnt_t'(HS_START);
    localparam cnt_t HSE = cnt_t'(HS_END);
    localparam cnt_t VBS = cnt_t'(VB_START);
    localparam cnt_t VBE = cnt_t'(VB_END);
    localparam cnt_t VSS = cnt_t'(VS_START);
    localparam cnt_t VSE = cnt_t'(VS_END);

    cnt_t h, v;
    cnt_t h_nx, v_nx;
    logic h_wrap, v_wrap;
    logic flip_l, hinit;
    logic lhbl, lvbl, ims, hs, vs;
    logic lvbl_nx;

    jtdd_tcnt #(.W(CW), .MAX(HTOTAL)) u_hcnt (
        .clk    (clk),
        .nRESET (nRESET),
        .en     (vid.cen6),
        .cnt    (h),
        .nxt    (h_nx),
        .wrap   (h_wrap)
    );

    jtdd_tcnt #(.W(CW), .MAX(VTOTAL)) u_vcnt (
        .clk    (clk),
        .nRESET (nRESET),
        .en     (h_wrap),
        .cnt    (v),
        .nxt    (v_nx),
        .wrap   (v_wrap)
    );

    // Edge-set blanking so the window can straddle the V wrap.
    always_comb begin
        lvbl_nx = lvbl;
        unique case (1'b1)
            (v_nx == VBS): lvbl_nx = 1'b0;
            (v_nx == VBE): lvbl_nx = 1'b1;
            default:       lvbl_nx = lvbl;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            flip_l <= 1'b0;
            hinit  <= 1'b0;
            lhbl   <= 1'b1;
            lvbl   <= 1'b0;
            ims    <= 1'b0;
            hs     <= 1'b1;
            vs     <= 1'b1;
        end else begin
            hinit <= (h_nx == '0);
            if (vid.cen6) begin
                lhbl <= (h_nx < HB);
                lvbl <= lvbl_nx;
                ims  <= (h_nx >= HB)
                     && (v_nx[3:0] == 4'hF)
                     && lvbl_nx;
                hs   <= !in_win(h_nx, HSS, HSE);
                vs   <= !in_win(v_nx, VSS, VSE);
                if (v_wrap)
                    flip_l <= vid.flip;
            end
        end
    end

    assign vid.H     = h;
    assign vid.V     = v;
    assign vid.HF    = h[7:0] ^ {8{flip_l}};
    assign vid.VF    = v[7:0] ^ {8{flip_l}};
    assign vid.Hinit = hinit;
    assign vid.LHBL  = lhbl;
    assign vid.LVBL  = lvbl;
    assign vid.VBL   = ~lvbl;
    assign vid.IMS   = ims;
    assign vid.HS    = hs;
    assign vid.VS    = vs;

endmodule

// File: tb/tb_jtdd_timing.sv
// tb_jtdd_timing: randomized cen6 spacing and flip requests checked
// against an arithmetic raster model; H shortened to keep frames quick.
module tb_jtdd_timing;

    localparam int HT  = 48;
    localparam int HB  = 32;
    localparam int HSS = 36;
    localparam int HSE = 39;
    localparam int VT  = 272;
    localparam int VBS = 248;
    localparam int VBE = 8;
    localparam int VSS = 252;
    localparam int VSE = 255;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic [7:0] hf;
        logic [7:0] vf;
        logic       hinit;
        logic       lhbl;
        logic       lvbl;
        logic       vbl;
        logic       ims;
        logic       hs;
        logic       vs;
    } obs_t;

    logic clk = 1'b0;
    logic nRESET;
    int   errors = 0;
    int   checks = 0;
    int   mh, mv;
    bit   mflip;

    jtdd_timing_if vif();

    jtdd_timing #(
        .HTOTAL   (HT),
        .VTOTAL   (VT),
        .HB_START (HB),
        .HS_START (HSS),
        .HS_END   (HSE),
        .VB_START (VBS),
        .VB_END   (VBE),
        .VS_START (VSS),
        .VS_END   (VSE)
    ) dut (
        .clk    (clk),
        .nRESET (nRESET),
        .vid    (vif)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.h     = vif.H;
        o.v     = vif.V;
        o.hf    = vif.HF;
        o.vf    = vif.VF;
        o.hinit = vif.Hinit;
        o.lhbl  = vif.LHBL;
        o.lvbl  = vif.LVBL;
        o.vbl   = vif.VBL;
        o.ims   = vif.IMS;
        o.hs    = vif.HS;
        o.vs    = vif.VS;
        return o;
    endfunction

    function automatic obs_t expect_out();
        obs_t e;
        bit   lv;
        logic [7:0] fm;
        lv      = (mv >= VBE) && (mv < VBS);
        fm      = mflip ? 8'hFF : 8'h00;
        e.h     = 9'(mh);
        e.v     = 9'(mv);
        e.hf    = 8'(mh % 256) ^ fm;
        e.vf    = 8'(mv % 256) ^ fm;
        e.hinit = (mh == 0);
        e.lhbl  = (mh < HB);
        e.lvbl  = lv;
        e.vbl   = !lv;
        e.ims   = (mh >= HB) && (mv % 16 == 15) && lv;
        e.hs    = !(mh >= HSS && mh <= HSE);
        e.vs    = !(mv >= VSS && mv <= VSE);
        return e;
    endfunction

    function automatic void advance(bit fl);
        if (mh == HT - 1) begin
            mh = 0;
            if (mv == VT - 1) begin
                mv    = 0;
                mflip = fl;
            end else begin
                mv++;
            end
        end else begin
            mh++;
        end
    endfunction

    // One cen6 strobe, then a random idle gap; ends on a negedge.
    task automatic pulse();
        int gap;
        vif.cen6 = 1'b1;
        @(negedge clk);
        vif.cen6 = 1'b0;
        advance(vif.flip);
        gap = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_to(int h, int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < HT * VT) begin
            pulse();
            n++;
        end
        checks++;
        if (vif.H !== 9'(h) || vif.V !== 9'(v)) begin
            errors++;
            $display("FAIL run_to: got H=%0d V=%0d want H=%0d V=%0d",
                     vif.H, vif.V, h, v);
        end
    endtask

    task automatic test_reset();
        obs_t o;
        nRESET   = 1'b0;
        vif.cen6 = 1'b0;
        vif.flip = 1'b0;
        repeat (3) @(negedge clk);
        vif.cen6 = 1'b1;
        repeat (2) @(negedge clk);
        vif.cen6 = 1'b0;
        o = observe();
        checks++;
        if (o.h !== 9'd0 || o.v !== 9'd0) begin
            errors++;
            $display("FAIL reset_hv: got H=%0d V=%0d want 0 0", o.h, o.v);
        end
        checks++;
        if (o.lhbl !== 1'b1) begin
            errors++;
            $display("FAIL reset_lhbl: got %b want 1", o.lhbl);
        end
        checks++;
        if (o.lvbl !== 1'b0 || o.vbl !== 1'b1) begin
            errors++;
            $display("FAIL reset_vbl: got LVBL=%b VBL=%b want 0 1",
                     o.lvbl, o.vbl);
        end
        checks++;
        if (o.hs !== 1'b1 || o.vs !== 1'b1) begin
            errors++;
            $display("FAIL reset_sync: got HS=%b VS=%b want 1 1",
                     o.hs, o.vs);
        end
        checks++;
        if (o.ims !== 1'b0 || o.hinit !== 1'b0) begin
            errors++;
            $display("FAIL reset_ims_hinit: got %b %b want 0 0",
                     o.ims, o.hinit);
        end
        checks++;
        if (o.hf !== 8'h00 || o.vf !== 8'h00) begin
            errors++;
            $display("FAIL reset_flip: got HF=%h VF=%h want 00 00",
                     o.hf, o.vf);
        end
        mh     = 0;
        mv     = 0;
        mflip  = 1'b0;
        nRESET = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_line();
        int seen = 0;
        for (int i = 0; i < HT; i++) begin
            if (vif.Hinit === 1'b1) seen++;
            pulse();
            if (i == 0) begin
                checks++;
                if (vif.H !== 9'd1 || vif.V !== 9'd0
                    || vif.LVBL !== 1'b0) begin
                    errors++;
                    $display("FAIL first_cen6: got H=%0d V=%0d LVBL=%b want 1 0 0",
                             vif.H, vif.V, vif.LVBL);
                end
            end
        end
        if (vif.Hinit === 1'b1) seen++;
        checks++;
        if (seen != 2) begin
            errors++;
            $display("FAIL hinit_count: got %0d want 2", seen);
        end
        checks++;
        if (vif.H !== 9'd0 || vif.V !== 9'd1) begin
            errors++;
            $display("FAIL line_wrap: got H=%0d V=%0d want 0 1",
                     vif.H, vif.V);
        end
    endtask

    task automatic test_frame();
        obs_t o, e;
        int   bad = 0, fh = -1, fv = -1;
        int   falls = 0, rises = 0, fall_v = -1, rise_v = -1;
        int   vbl_lines = 0;
        logic prev;
        prev = vif.LVBL;
        for (int i = 0; i < HT * VT; i++) begin
            if ($urandom_range(0, 299) == 0) vif.flip = ~vif.flip;
            pulse();
            o = observe();
            e = expect_out();
            if (o !== e) begin
                bad++;
                if (fv < 0) begin
                    fh = mh;
                    fv = mv;
                end
            end
            if (prev === 1'b1 && o.lvbl === 1'b0) begin
                falls++;
                fall_v = int'(o.v);
            end
            if (prev === 1'b0 && o.lvbl === 1'b1) begin
                rises++;
                rise_v = int'(o.v);
            end
            prev = o.lvbl;
            if (o.h === 9'd0 && o.vbl === 1'b0) vbl_lines++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL frame_model: got %0d bad samples (first H=%0d V=%0d) want 0",
                     bad, fh, fv);
        end
        checks++;
        if (falls != 1 || fall_v != VBS) begin
            errors++;
            $display("FAIL lvbl_fall: got %0d falls at V=%0d want 1 at %0d",
                     falls, fall_v, VBS);
        end
        checks++;
        if (rises != 1 || rise_v != VBE) begin
            errors++;
            $display("FAIL lvbl_rise: got %0d rises at V=%0d want 1 at %0d",
                     rises, rise_v, VBE);
        end
        checks++;
        if (vbl_lines != 240) begin
            errors++;
            $display("FAIL vbl_lines: got %0d want 240", vbl_lines);
        end
    endtask

    task automatic test_ims();
        int   edges = 0, badpos = 0, first_v = -1, last_v = -1;
        logic prev;
        vif.flip = 1'b0;
        prev = vif.IMS;
        for (int i = 0; i < HT * VT; i++) begin
            pulse();
            if (prev === 1'b0 && vif.IMS === 1'b1) begin
                edges++;
                if (vif.H !== 9'(HB) || vif.V[3:0] !== 4'hF) badpos++;
                if (first_v < 0) first_v = int'(vif.V);
                last_v = int'(vif.V);
            end
            prev = vif.IMS;
        end
        checks++;
        if (edges != 15) begin
            errors++;
            $display("FAIL ims_edges: got %0d want 15", edges);
        end
        checks++;
        if (badpos != 0) begin
            errors++;
            $display("FAIL ims_pos: got %0d misplaced edges want 0", badpos);
        end
        checks++;
        if (first_v != 15 || last_v != 239) begin
            errors++;
            $display("FAIL ims_span: got V=%0d..%0d want 15..239",
                     first_v, last_v);
        end
    endtask

    task automatic test_flip();
        int bad = 0, n = 0;
        run_to(0, 100);
        vif.flip = 1'b1;
        pulse();
        while (!(mh == 0 && mv == 0) && n < HT * VT) begin
            if (vif.HF !== 8'(mh % 256) || vif.VF !== 8'(mv % 256)) bad++;
            pulse();
            n++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flip_midframe: got %0d early flips want 0", bad);
        end
        run_to(5, 0);
        checks++;
        if (vif.HF !== 8'hFA || vif.VF !== 8'hFF) begin
            errors++;
            $display("FAIL flip_frame: got HF=%h VF=%h want fa ff",
                     vif.HF, vif.VF);
        end
    endtask

    task automatic test_hold();
        obs_t o0;
        int   bad = 0;
        run_to(20, mv);
        o0 = observe();
        repeat (50) begin
            @(negedge clk);
            if (observe() !== o0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold: got %0d changed samples want 0", bad);
        end
        pulse();
        checks++;
        if (vif.H !== 9'd21 || observe() !== expect_out()) begin
            errors++;
            $display("FAIL resume: got H=%0d want 21", vif.H);
        end
    endtask

    task automatic test_midreset();
        obs_t o;
        run_to(40, 130);
        checks++;
        if (observe() !== expect_out()) begin
            errors++;
            $display("FAIL pre_reset: got %h want %h",
                     observe(), expect_out());
        end
        #2;
        nRESET = 1'b0;
        #1;
        o = observe();
        checks++;
        if (o.h !== 9'd0 || o.v !== 9'd0 || o.hf !== 8'h00
            || o.vf !== 8'h00) begin
            errors++;
            $display("FAIL async_hv: got H=%0d V=%0d HF=%h want 0 0 00",
                     o.h, o.v, o.hf);
        end
        checks++;
        if (o.lhbl !== 1'b1 || o.lvbl !== 1'b0 || o.vbl !== 1'b1
            || o.ims !== 1'b0 || o.hs !== 1'b1 || o.vs !== 1'b1
            || o.hinit !== 1'b0) begin
            errors++;
            $display("FAIL async_flags: got %b%b%b%b%b%b%b want 1010110",
                     o.lhbl, o.lvbl, o.vbl, o.ims, o.hs, o.vs, o.hinit);
        end
        @(negedge clk);
        nRESET = 1'b1;
        mh     = 0;
        mv     = 0;
        mflip  = 1'b0;
        repeat (2) @(negedge clk);
        pulse();
        checks++;
        if (observe() !== expect_out() || vif.H !== 9'd1) begin
            errors++;
            $display("FAIL post_reset: got %h want %h",
                     observe(), expect_out());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_ims();
        test_flip();
        test_hold();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
